if_bus_ctrl: RTL

//  Instruction-fetch bus master; sits directly upstream of the IF pipeline register.

---
 rtl/if_bus_ctrl_pkg.sv | 20 ++
 rtl/if_bus_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_bus_ctrl_pkg.sv
// Shared constants for the instruction-fetch bus master.
// Holds bus widths, FSM state encodings, the NOP word and enable levels.
package if_bus_ctrl_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  // FSM state encodings (2 bits)
  localparam logic [1:0] IF_BUS_IDLE   = 2'd0;
  localparam logic [1:0] IF_BUS_REQ    = 2'd1;
  localparam logic [1:0] IF_BUS_ACCESS = 2'd2;
  localparam logic [1:0] IF_BUS_HOLD   = 2'd3;

  // Word presented to the IF register when nothing valid is available
  localparam logic [DATA_W-1:0] ISA_NOP = DATA_W'(32'h0000_0000);

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/if_bus_ctrl.sv
// Instruction-fetch bus master sitting in front of the IF pipeline register.
// Runs request/grant/ready transactions for the next PC and hands the fetched
// word to the pipeline, parking it in a one-entry buffer while the pipe stalls.
// Ports:
//   clk, reset_            clock, synchronous active-high reset
//   Addr, Req              next fetch word address and fetch request
//   Stall, Flush           pipeline stall / flush
//   BusReq, BusGrnt        arbiter request (registered) and grant
//   BusAs_, BusAddr        address strobe (active-low) and fetch address (registered)
//   BusRdy, BusRdData      read data valid and read data
//   Insn, Busy             fetched word (or NOP) and stall request (combinational)
module if_bus_ctrl
  import if_bus_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Req,
  input  logic              Stall,
  input  logic              Flush,
  output logic              BusReq,
  input  logic              BusGrnt,
  output logic              BusAs_,
  output logic [ADDR_W-1:0] BusAddr,
  input  logic              BusRdy,
  input  logic [DATA_W-1:0] BusRdData,
  output logic [DATA_W-1:0] Insn,
  output logic              Busy
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] buffer;
  logic [DATA_W-1:0] buffer_nxt;
  logic              discard;
  logic              discard_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              word_ok;
  logic              deliver;

  // State, buffer and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset_) begin
      state   <= IF_BUS_IDLE;
      buffer  <= ISA_NOP;
      discard <= 1'b0;
      BusAddr <= '0;
      BusReq  <= DISABLE;
      BusAs_  <= 1'b1;
    end else begin
      state   <= state_nxt;
      buffer  <= buffer_nxt;
      discard <= discard_nxt;
      BusAddr <= addr_nxt;
      // Bus outputs are decoded from the next state so they track the state register
      BusReq  <= (state_nxt == IF_BUS_REQ) || (state_nxt == IF_BUS_ACCESS);
      BusAs_  <= (state_nxt != IF_BUS_ACCESS);
    end
  end

  // Word delivery to the pipeline: returned bus word or the parked buffer
  always_comb begin
    word_ok = (state == IF_BUS_ACCESS) && BusRdy && !discard && !Flush;
    deliver = (word_ok && !Stall) ||
              ((state == IF_BUS_HOLD) && !Stall && !Flush);
    Insn    = ISA_NOP;
    if (word_ok) begin
      Insn = BusRdData;
    end else if (state == IF_BUS_HOLD) begin
      Insn = buffer;
    end
    Busy = Req && !deliver && !Flush;
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    buffer_nxt  = buffer;
    discard_nxt = discard;
    addr_nxt    = BusAddr;
    case (state)
      IF_BUS_IDLE: begin
        if (Req && !Flush) state_nxt = IF_BUS_REQ;
      end
      IF_BUS_REQ: begin
        if (Flush) begin
          state_nxt = IF_BUS_IDLE;
        end else if (BusGrnt) begin
          state_nxt   = IF_BUS_ACCESS;
          addr_nxt    = Addr;
          discard_nxt = 1'b0;
        end
      end
      IF_BUS_ACCESS: begin
        if (BusRdy) begin
          if (discard || Flush) begin
            state_nxt = (Req && !Flush) ? IF_BUS_REQ : IF_BUS_IDLE;
          end else if (Stall) begin
            buffer_nxt = BusRdData;
            state_nxt  = IF_BUS_HOLD;
          end else begin
            state_nxt = Req ? IF_BUS_REQ : IF_BUS_IDLE;
          end
        end else if (Flush) begin
          // The bus cycle cannot be aborted; remember to drop its data
          discard_nxt = 1'b1;
        end
      end
      IF_BUS_HOLD: begin
        if (Flush) begin
          state_nxt  = IF_BUS_IDLE;
          buffer_nxt = ISA_NOP;
        end else if (!Stall) begin
          state_nxt = Req ? IF_BUS_REQ : IF_BUS_IDLE;
        end
      end
      default: state_nxt = IF_BUS_IDLE;
    endcase
  end

endmodule
